// File: rtl/rbm_recon_layer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rbm_recon_layer                                            |
// | Description : RBM visible-layer reconstruction. One unit per LOAD/ACC/ACT |
// |               pass, hard-sigmoid activation and per-unit sampling.       |
// |               Optional macro RBM_RECON_SAMPLE_EN selects LFSR sampling.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rbm_recon_layer #(
    parameter int          input_bitlength   = 12,
    parameter int          sigmoid_bitlength = 8,
    parameter int          in_dim            = 15,
    parameter int          h_dim             = 5,
    parameter int          sigmoid_shift     = 2,
    parameter logic [15:0] seed              = 16'hACE1
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [h_dim-1:0]                            H_State,
    input  logic [in_dim*h_dim*input_bitlength-1:0]     H_WeightI,
    input  logic [in_dim*input_bitlength-1:0]           V_BiasI,
    output logic                                        busy,
    output logic                                        done,
    output logic [in_dim*sigmoid_bitlength-1:0]         V_Prob,
    output logic [in_dim-1:0]                           V_Sample
);

    localparam int c_ACC_W = input_bitlength + $clog2(h_dim + 1);
    localparam int c_IW    = (in_dim > 1) ? $clog2(in_dim) : 1;
    localparam int c_JW    = (h_dim > 1) ? $clog2(h_dim) : 1;
    localparam logic [c_IW-1:0] c_I_LAST = c_IW'(in_dim - 1);
    localparam logic [c_JW-1:0] c_J_LAST = c_JW'(h_dim - 1);
    localparam logic signed [c_ACC_W:0] c_OFFSET = (c_ACC_W + 1)'(2 ** (sigmoid_bitlength - 1));
    localparam logic signed [c_ACC_W:0] c_PMAX   = (c_ACC_W + 1)'(2 ** sigmoid_bitlength - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ACC  = 3'd2,
        ACT  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t r_state, w_next;

    logic [h_dim-1:0]                    r_h;
    logic signed [c_ACC_W-1:0]           r_acc;
    logic [c_IW-1:0]                     r_i;
    logic [c_JW-1:0]                     r_j;
    logic [in_dim*sigmoid_bitlength-1:0] r_v_prob;
    logic [in_dim-1:0]                   r_v_sample;

    logic [input_bitlength-1:0]          w_weight;
    logic [input_bitlength-1:0]          w_bias;
    logic signed [c_ACC_W-1:0]           w_weight_ext;
    logic signed [c_ACC_W-1:0]           w_bias_ext;
    logic signed [c_ACC_W-1:0]           w_shift;
    logic signed [c_ACC_W:0]             w_sum;
    logic [sigmoid_bitlength-1:0]        w_p;
    logic                                w_sample;
    int                                  w_widx;

    always_comb begin
        w_widx       = int'(r_i) * h_dim + int'(r_j);
        w_weight     = H_WeightI[w_widx*input_bitlength +: input_bitlength];
        w_bias       = V_BiasI[int'(r_i)*input_bitlength +: input_bitlength];
        w_weight_ext = {{(c_ACC_W-input_bitlength){w_weight[input_bitlength-1]}}, w_weight};
        w_bias_ext   = {{(c_ACC_W-input_bitlength){w_bias[input_bitlength-1]}}, w_bias};
    end

    // Hard sigmoid: scaled pre-activation recentred on mid-scale, then saturated.
    always_comb begin
        w_shift = r_acc >>> sigmoid_shift;
        w_sum   = {w_shift[c_ACC_W-1], w_shift} + c_OFFSET;
        if (w_sum < 0)
            w_p = '0;
        else if (w_sum > c_PMAX)
            w_p = '1;
        else
            w_p = w_sum[sigmoid_bitlength-1:0];
    end

`ifdef RBM_RECON_SAMPLE_EN
    logic [15:0] r_lfsr;

    always_comb w_sample = (r_lfsr[sigmoid_bitlength-1:0] < w_p);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_lfsr <= seed;
        else if (r_state == ACT)
            r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
    end
`else
    always_comb w_sample = w_p[sigmoid_bitlength-1];
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = LOAD;
            LOAD: begin
                busy   = 1'b1;
                w_next = ACC;
            end
            ACC: begin
                busy = 1'b1;
                if (r_j == c_J_LAST) w_next = ACT;
            end
            ACT: begin
                busy   = 1'b1;
                w_next = (r_i == c_I_LAST) ? DONE : LOAD;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_h        <= '0;
            r_acc      <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_v_prob   <= '0;
            r_v_sample <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_h <= H_State;
                    r_i <= '0;
                end
                LOAD: begin
                    r_acc <= w_bias_ext;
                    r_j   <= '0;
                end
                ACC: begin
                    if (r_h[r_j]) r_acc <= r_acc + w_weight_ext;
                    r_j <= r_j + 1'b1;
                end
                ACT: begin
                    r_v_prob[int'(r_i)*sigmoid_bitlength +: sigmoid_bitlength] <= w_p;
                    r_v_sample[r_i] <= w_sample;
                    if (r_i != c_I_LAST) r_i <= r_i + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign V_Prob   = r_v_prob;
    assign V_Sample = r_v_sample;

endmodule
`default_nettype wire
